pcileech_board_ctl: RTL and testbench
=====================================

PCILEECH_BOARD_CTL -- requirements
Module: pcileech_board_ctl

Interface
REQ-001 The block SHALL have parameter NUM_BTN, default 2, number of active-low user buttons; button 0 is the soft-reset button.
REQ-002 The block SHALL have parameter NUM_LED, default 2, number of activity LEDs.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive differing samples required to change a debounced level (min 2).
REQ-004 The block SHALL have parameter LED_STRETCH_CYCLES, default 10000000, LED on-time per activity pulse (min 1).
REQ-005 The block SHALL have parameter RST_HOLD_CYCLES, default 256, system-reset assertion length (min 1).
REQ-006 The block SHALL have parameter PCIE_RST_DELAY_CYCLES, default 1024, PCIe reset extension after system reset release (min 1).
REQ-007 The block SHALL have port clk  input  1  single system clock, 100 MHz.
REQ-008 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 The block SHALL have port btn_n  input  NUM_BTN  raw asynchronous buttons, low = pressed.
REQ-010 The block SHALL have port pcie_perst_n_in  input  1  raw asynchronous PCIe PERST#.
REQ-011 The block SHALL have port led_act  input  NUM_LED  one-cycle activity strobes.
REQ-012 The block SHALL have port led_invert  input  1  inverts all LED outputs.
REQ-013 The block SHALL have port btn_level  output  NUM_BTN  debounced level, 1 = pressed.
REQ-014 The block SHALL have port btn_press  output  NUM_BTN  one-cycle pulse on each debounced 0->1 transition.
REQ-015 The block SHALL have port sys_rst_out  output  1  synchronous active-high reset for downstream logic.
REQ-016 The block SHALL have port pcie_rst_n_out  output  1  active-low reset for the PCIe core.
REQ-017 The block SHALL have port led_out  output  NUM_LED  LED drive.

Function
REQ-018 btn_n and pcie_perst_n_in SHALL each pass through a 2-flop synchronizer before any use.
REQ-019 Per button: when synced pressed-sample equals btn_level, the counter SHALL clear; when it differs, the counter SHALL increment; btn_level SHALL flip on the DEBOUNCE_CYCLES-th consecutive differing edge, with the counter clearing at the same edge.
REQ-020 btn_press[i] SHALL be high for exactly the one cycle following btn_level[i] 0->1; no pulse on 1->0.
REQ-021 Per LED: led_act[i]=1 SHALL load LED_STRETCH_CYCLES, retriggering and overriding the decrement; otherwise a non-zero counter SHALL decrement by 1; zero SHALL hold.
REQ-022 led_out[i] SHALL equal (counter[i]!=0) XOR led_invert, combinationally from the counter register.
REQ-023 The sequencer FSM SHALL have states S_RST, S_SYS_HOLD, S_PCIE_WAIT and S_RUN, with a shared down-counter.
REQ-024 S_RST SHALL pass to S_SYS_HOLD on the first edge after reset release, loading the counter with RST_HOLD_CYCLES-1.
REQ-025 S_SYS_HOLD SHALL decrement the counter and, at 0, pass to S_PCIE_WAIT, loading PCIE_RST_DELAY_CYCLES-1.
REQ-026 S_PCIE_WAIT SHALL decrement the counter and, at 0, pass to S_RUN.
REQ-027 btn_press[0] in S_SYS_HOLD, S_PCIE_WAIT or S_RUN SHALL force S_SYS_HOLD with the counter reloaded to RST_HOLD_CYCLES-1, taking priority over the counter expiry in the same cycle.
REQ-028 sys_rst_out SHALL be 1 in S_RST and S_SYS_HOLD and 0 otherwise, and SHALL be registered.
REQ-029 pcie_rst_n_out SHALL be 0 outside S_RUN; in S_RUN it SHALL equal synced PERST#, and a PERST# low in S_RUN SHALL not change state.

Reset
REQ-030 Asynchronous rst SHALL force: FSM S_RST, sys_rst_out=1, pcie_rst_n_out=0, btn_level=0, btn_press=0, all counters 0, synchronizer flops to the idle level (1), and led_out=led_invert replicated.
REQ-031 rst asserted mid-sequence or mid-debounce SHALL abort immediately; no partial state SHALL survive.

Structure
REQ-032 The state enum and minimum-parameter constants SHALL reside in shared package pcileech_board_pkg.
REQ-033 Synchronizer plus debounce SHALL be one sub-module, pcileech_debounce, instantiated NUM_BTN times; counter widths SHALL be $clog2(param+1).

Verification (DEBOUNCE=4, STRETCH=3, RST_HOLD=5, PCIE_DELAY=6, NUM_BTN=NUM_LED=2)
REQ-034 Release rst -> sys_rst_out=1 for 6 edges, pcie_rst_n_out rises exactly 6 edges after sys_rst_out falls (PERST# high).
REQ-035 btn_n[1] low 3 cycles then high -> no btn_level change; held 20 cycles -> btn_level[1]=1 after 6 edges, a single btn_press[1] pulse.
REQ-036 btn_press[0] in S_RUN -> sys_rst_out=1, pcie_rst_n_out=0; second press during S_PCIE_WAIT restarts the 5-cycle hold.
REQ-037 led_act[0] pulse, then a retrigger 2 cycles later -> led_out[0]=1 for 5 cycles total; led_invert=1 -> pattern inverted.
REQ-038 PERST# low in S_RUN -> pcie_rst_n_out low 2 edges later, FSM stays S_RUN; rst mid-S_PCIE_WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/pcileech_board_pkg.sv
// rtl/pcileech_board_pkg.sv - shared types and constants for the board control block
// Holds the reset-sequencer state encoding, the lower bounds applied to the
// timing parameters, and a small clamp helper used by the design files.
package pcileech_board_pkg;

    typedef enum logic [1:0] {
        S_RST       = 2'd0,
        S_SYS_HOLD  = 2'd1,
        S_PCIE_WAIT = 2'd2,
        S_RUN       = 2'd3
    } board_state_e;

    localparam int MIN_DEBOUNCE_CYCLES       = 2;
    localparam int MIN_LED_STRETCH_CYCLES    = 1;
    localparam int MIN_RST_HOLD_CYCLES       = 1;
    localparam int MIN_PCIE_RST_DELAY_CYCLES = 1;

    // Parameters below their minimum are raised to it rather than
    // producing zero-width counters or wrapped reload values.
    function automatic int clamp_min(input int value, input int floor_v);
        return (value < floor_v) ? floor_v : value;
    endfunction

endpackage

// File: rtl/pcileech_debounce.sv
// rtl/pcileech_debounce.sv - two-flop synchronizer plus debounce for one active-low button
// Ports: clk/rst (async active-high), btn_n_i raw button (low = pressed),
// level_o debounced level (1 = pressed), press_o one-cycle pulse on 0->1.
module pcileech_debounce
    import pcileech_board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o
);

    localparam int DB    = clamp_min(DEBOUNCE_CYCLES, MIN_DEBOUNCE_CYCLES);
    localparam int CNT_W = $clog2(DB + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_s;

    assign pressed_s = ~sync2_q;

    // Any sample that agrees with the current level restarts the run, so
    // only DB consecutive disagreeing samples can flip the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (pressed_s != level_q) begin
            if (cnt_q == CNT_W'(DB - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= level_d & ~level_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/pcileech_board_ctl.sv
// rtl/pcileech_board_ctl.sv - buttons, activity LEDs and reset sequencing for the board
// Ports: clk/rst (async active-high), btn_n raw buttons, pcie_perst_n_in raw
// PERST#, led_act activity strobes, led_invert LED polarity; outputs
// btn_level/btn_press debounced buttons, sys_rst_out, pcie_rst_n_out, led_out.
// Button 0 is the soft-reset button feeding the sequencer.
module pcileech_board_ctl
    import pcileech_board_pkg::*;
#(
    parameter int NUM_BTN               = 2,
    parameter int NUM_LED               = 2,
    parameter int DEBOUNCE_CYCLES       = 1000000,
    parameter int LED_STRETCH_CYCLES    = 10000000,
    parameter int RST_HOLD_CYCLES       = 256,
    parameter int PCIE_RST_DELAY_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic               pcie_perst_n_in,
    input  logic [NUM_LED-1:0] led_act,
    input  logic               led_invert,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               sys_rst_out,
    output logic               pcie_rst_n_out,
    output logic [NUM_LED-1:0] led_out
);

    localparam int STRETCH = clamp_min(LED_STRETCH_CYCLES, MIN_LED_STRETCH_CYCLES);
    localparam int RH      = clamp_min(RST_HOLD_CYCLES, MIN_RST_HOLD_CYCLES);
    localparam int PD      = clamp_min(PCIE_RST_DELAY_CYCLES, MIN_PCIE_RST_DELAY_CYCLES);
    localparam int LED_W   = $clog2(STRETCH + 1);
    localparam int SEQ_MAX = (RH > PD) ? RH : PD;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        pcileech_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .btn_n_i(btn_n[b]),
            .level_o(btn_level[b]),
            .press_o(btn_press[b])
        );
    end

    // Activity LEDs: a strobe reloads the full on-time even mid-countdown.
    for (genvar l = 0; l < NUM_LED; l++) begin : g_led
        logic [LED_W-1:0] led_cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                led_cnt_q <= '0;
            end else if (led_act[l]) begin
                led_cnt_q <= LED_W'(STRETCH);
            end else if (led_cnt_q != '0) begin
                led_cnt_q <= led_cnt_q - LED_W'(1);
            end
        end

        assign led_out[l] = (led_cnt_q != '0) ^ led_invert;
    end

    logic perst_s1_q;
    logic perst_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perst_s1_q <= 1'b1;
            perst_s2_q <= 1'b1;
        end else begin
            perst_s1_q <= pcie_perst_n_in;
            perst_s2_q <= perst_s1_q;
        end
    end

    board_state_e     state_q;
    board_state_e     state_d;
    logic [SEQ_W-1:0] seq_cnt_q;
    logic [SEQ_W-1:0] seq_cnt_d;
    logic             sys_rst_q;
    logic             sys_rst_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            seq_cnt_q <= '0;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
            sys_rst_q <= sys_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        case (state_q)
            S_RST: begin
                state_d   = S_SYS_HOLD;
                seq_cnt_d = SEQ_W'(RH - 1);
            end
            S_SYS_HOLD: begin
                if (seq_cnt_q == '0) begin
                    state_d   = S_PCIE_WAIT;
                    seq_cnt_d = SEQ_W'(PD - 1);
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            S_PCIE_WAIT: begin
                if (seq_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    seq_cnt_d = seq_cnt_q - SEQ_W'(1);
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
        // Soft reset overrides any expiry happening in the same cycle.
        if (state_q != S_RST && btn_press[0]) begin
            state_d   = S_SYS_HOLD;
            seq_cnt_d = SEQ_W'(RH - 1);
        end
    end

    // sys_rst is registered from the next state so it tracks the FSM
    // without a one-cycle lag.
    always_comb begin
        sys_rst_d      = (state_d == S_RST) || (state_d == S_SYS_HOLD);
        pcie_rst_n_out = (state_q == S_RUN) && perst_s2_q;
    end

    assign sys_rst_out = sys_rst_q;

endmodule

// File: tb/tb_pcileech_board_ctl.sv
// tb/tb_pcileech_board_ctl.sv - self-checking bench for pcileech_board_ctl
module tb_pcileech_board_ctl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_n;
    logic       perst_n;
    logic [1:0] led_act;
    logic       led_invert;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic       sys_rst_out;
    logic       pcie_rst_n_out;
    logic [1:0] led_out;

    always #5 clk = ~clk;

    pcileech_board_ctl #(
        .NUM_BTN              (2),
        .NUM_LED              (2),
        .DEBOUNCE_CYCLES      (4),
        .LED_STRETCH_CYCLES   (3),
        .RST_HOLD_CYCLES      (5),
        .PCIE_RST_DELAY_CYCLES(6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_n          (btn_n),
        .pcie_perst_n_in(perst_n),
        .led_act        (led_act),
        .led_invert     (led_invert),
        .btn_level      (btn_level),
        .btn_press      (btn_press),
        .sys_rst_out    (sys_rst_out),
        .pcie_rst_n_out (pcie_rst_n_out),
        .led_out        (led_out)
    );

    typedef struct {
        logic [1:0] act;
        logic       inv;
        logic [1:0] exp_led;
    } led_vec_t;

    led_vec_t   vecs[13];
    logic [1:0] sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         n;
    int         presses;
    logic       seen;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // STRETCH=3; act/invert applied before an edge, LED value seen after it.
        vecs[0]  = '{2'b01, 1'b0, 2'b01};
        vecs[1]  = '{2'b00, 1'b0, 2'b01};
        vecs[2]  = '{2'b01, 1'b0, 2'b01};
        vecs[3]  = '{2'b00, 1'b0, 2'b01};
        vecs[4]  = '{2'b00, 1'b0, 2'b01};
        vecs[5]  = '{2'b00, 1'b0, 2'b00};
        vecs[6]  = '{2'b10, 1'b1, 2'b01};
        vecs[7]  = '{2'b00, 1'b1, 2'b01};
        vecs[8]  = '{2'b11, 1'b1, 2'b00};
        vecs[9]  = '{2'b00, 1'b0, 2'b11};
        vecs[10] = '{2'b00, 1'b0, 2'b11};
        vecs[11] = '{2'b00, 1'b1, 2'b11};
        vecs[12] = '{2'b00, 1'b0, 2'b00};

        rst        = 1'b1;
        btn_n      = 2'b11;
        perst_n    = 1'b1;
        led_act    = 2'b00;
        led_invert = 1'b1;
        repeat (2) tick;
        check("rst_led_inv", led_out, 2'b11);
        led_invert = 1'b0;
        #1;
        check("rst_led", led_out, 2'b00);
        check("rst_sys_rst", sys_rst_out, 1);
        check("rst_pcie", pcie_rst_n_out, 0);
        check("rst_btn_level", btn_level, 0);
        check("rst_btn_press", btn_press, 0);

        // Power-on sequence.
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin tick; n++; end while (sys_rst_out && n < 20);
        check("sys_rst_len", n, 6);
        n = 0;
        do begin tick; n++; end while (!pcie_rst_n_out && n < 20);
        check("pcie_delay", n, 6);

        // LED vectors through the scoreboard.
        for (int i = 0; i < 13; i++) begin
            led_act    = vecs[i].act;
            led_invert = vecs[i].inv;
            sb_q.push_back(vecs[i].exp_led);
            tick;
            led_act = 2'b00;
            check($sformatf("led_vec%0d", i), led_out, sb_q.pop_front());
        end
        led_invert = 1'b0;

        // Button 1: short glitch, then a long press.
        btn_n[1] = 1'b0;
        repeat (3) tick;
        btn_n[1] = 1'b1;
        seen = 1'b0;
        presses = 0;
        repeat (12) begin tick; seen |= btn_level[1]; presses += int'(btn_press[1]); end
        check("btn1_glitch_level", seen, 0);
        check("btn1_glitch_press", presses, 0);
        btn_n[1] = 1'b0;
        n = 0;
        presses = 0;
        do begin tick; n++; presses += int'(btn_press[1]); end while (!btn_level[1] && n < 30);
        check("btn1_latency", n, 6);
        repeat (14) begin tick; presses += int'(btn_press[1]); end
        check("btn1_press_count", presses, 1);
        check("btn1_level_held", btn_level[1], 1);
        check("btn1_no_soft_rst", sys_rst_out, 0);
        btn_n[1] = 1'b1;
        presses = 0;
        repeat (10) begin tick; presses += int'(btn_press[1]); end
        check("btn1_release_press", presses, 0);
        check("btn1_release_level", btn_level[1], 0);

        // PERST# in RUN.
        perst_n = 1'b0;
        tick;
        check("perst_1edge", pcie_rst_n_out, 1);
        tick;
        check("perst_2edge", pcie_rst_n_out, 0);
        check("perst_sys_rst", sys_rst_out, 0);
        perst_n = 1'b1;
        repeat (2) tick;
        check("perst_recover", pcie_rst_n_out, 1);

        // Soft reset from RUN.
        btn_n[0] = 1'b0;
        n = 0;
        do begin tick; n++; end while (!sys_rst_out && n < 30);
        check("soft_rst_latency", n, 7);
        check("soft_rst_pcie", pcie_rst_n_out, 0);
        btn_n[0] = 1'b1;
        n = 0;
        do begin tick; n++; end while (!pcie_rst_n_out && n < 60);
        check("soft_rst_recover", n, 11);
        repeat (4) tick;

        // Press landing in S_PCIE_WAIT after power-on restarts the hold.
        rst = 1'b1;
        tick;
        btn_n[0] = 1'b0;
        rst = 1'b0;
        repeat (6) tick;
        check("pwait_entered", sys_rst_out, 0);
        tick;
        check("pwait_restart", sys_rst_out, 1);
        check("pwait_pcie", pcie_rst_n_out, 0);
        n = 0;
        do begin tick; n++; end while (sys_rst_out && n < 30);
        check("pwait_hold_len", n, 5);

        // Async reset in the middle of S_PCIE_WAIT with LEDs and a button active.
        led_act = 2'b11;
        tick;
        led_act = 2'b00;
        check("pre_rst_led", led_out, 2'b11);
        check("pre_rst_level", btn_level[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_sys_rst", sys_rst_out, 1);
        check("abort_pcie", pcie_rst_n_out, 0);
        check("abort_level", btn_level, 0);
        check("abort_press", btn_press, 0);
        check("abort_led", led_out, 2'b00);
        led_invert = 1'b1;
        #1;
        check("abort_led_inv", led_out, 2'b11);
        btn_n = 2'b11;
        @(negedge clk);
        rst = 1'b0;
        tick;
        check("post_rst_led", led_out, 2'b11);
        check("post_rst_sys", sys_rst_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
